uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Standalone UART receiver that is the receiving end of the team's 8N1 UART transmitter.
- Samples the serial line, reassembles frames into bytes and buffers them in a small FIFO.
- The host pops bytes from the FIFO with a read-enable handshake.
- Sits between the pad-side `rx` line and the host logic; replaces ad-hoc loopback checking with a buffered, error-reporting receive path.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit period (≥4).
- DATA_BITS, 8, data bits per frame (5..8), LSB first.
- FIFO_DEPTH, 4, FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- rx  input  1  asynchronous serial line, idle high
- rd_en  input  1  pop FIFO head this cycle
- rxout  output  DATA_BITS  FIFO head byte; 0 when empty
- valid  output  1  FIFO not empty
- count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- rxdone  output  1  one-cycle pulse: good frame received and pushed
- frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
- overrun  output  1  one-cycle pulse: good frame dropped, FIFO full

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous, active-low.
- Reset, sampled on a clk edge with rst_n=0:
  - FSM goes to IDLE; bit counter, cycle counter and FIFO pointers clear.
  - Synchronizer flops set to 1.
  - All outputs 0: rxout=0, valid=0, count=0, pulses 0.
  - Reset mid-frame aborts the frame and empties the FIFO.
- `rx` passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- States: IDLE, START, DATA, STOP, (PARITY), WAIT_IDLE.
- IDLE: rx_s=0 → START, cyc=0.
- START: at cyc = CLKS_PER_BIT/2−1 sample rx_s.
  - 0 → DATA, cyc=0, bit=0.
  - 1 → IDLE (glitch rejected, no flag).
- DATA: at cyc = CLKS_PER_BIT−1 sample rx_s into shift register (LSB first); cyc=0, bit++.
  - After DATA_BITS samples → STOP (or PARITY when enabled).
- STOP: at cyc = CLKS_PER_BIT−1 sample rx_s.
  - 1 → push byte, → IDLE.
  - 0 → frame_err pulse, byte discarded, → WAIT_IDLE.
- WAIT_IDLE: stays until rx_s=1, then → IDLE. A held-low line (break) yields exactly one frame_err.
- Push timing:
  - rxdone, valid and count update on the clock edge after the stop-sample cycle.
  - rxout shows the head byte combinationally from FIFO storage.
- FIFO rules:
  - rd_en with valid=0: ignored.
  - Push when full with no pop: byte dropped, overrun pulses, rxdone stays 0.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overrun.
  - Push and pop in the same cycle when empty: push succeeds, pop ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Total latency from the start-bit falling edge on rx to rxdone ≈ 2 (synchronizer) + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT + 1 cycles.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds PARITY state between DATA and STOP and output `parity_err` (1-bit pulse).
  - Expects even parity; sampled at cyc = CLKS_PER_BIT−1.
  - On mismatch, continues to STOP; at a good stop bit, the byte is discarded and parity_err pulses instead of rxdone.
  - frame_err takes priority: if both parity and stop fail, only frame_err pulses.
- Undefined: no PARITY state, no parity_err port; frame is 8N1.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=4):
- Reset, then send 8N1 frame 0xA5 → rxdone one pulse; valid=1, count=1, rxout=0xA5; rd_en one cycle → valid=0, rxout=0.
- Low glitch of 4 cycles on idle rx → no state advance past START, no pulses, count stays 0.
- Frame 0x3C with stop bit forced low, line held low 100 cycles → exactly one frame_err pulse, count=0. A following frame 0x11 is received correctly.
- Send 5 frames 0x01..0x05 with no reads → count=4, overrun pulses on the 5th, rxout=0x01. Pops return 0x01..0x04.
- FIFO full; assert rd_en on the push cycle of a 5th frame 0x55 → no overrun, count=4. Pop order 0x02,0x03,0x04,0x55 (0x01 was popped).
- Assert rst_n=0 for one cycle mid-DATA of frame 0xFF with 2 bytes buffered → count=0, valid=0. Next full frame 0x0F is received correctly. With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 → parity_err pulse, no push.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small read-enable FIFO for received bytes.
// Optional even-parity checking and parity_err port: define UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rxout,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          rxdone,
    output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    output logic                          overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 rx_m, rx_s;
    logic [CW-1:0]        cyc;
    logic [BW-1:0]        bitn;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;

    // NOTE: synchronizer flops reset to the idle line level so reset release cannot fake a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

`ifndef UART_RX_PARITY_EN
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cyc       <= '0;
            bitn      <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cyc   <= '0;
                    end
                end
                START: begin
                    if (cyc == CYC_HALF) begin
                        cyc   <= '0;
                        bitn  <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (cyc == CYC_LAST) begin
                        cyc   <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        bitn  <= bitn + 1'b1;
                        if (bitn == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cyc == CYC_LAST) begin
                        cyc     <= '0;
                        par_bad <= ^{shreg, rx_s};
                        state   <= STOP;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cyc == CYC_LAST) begin
                        cyc <= '0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                            state <= IDLE;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // A break holds the line low; only its release re-arms start detection.
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Good stop bit sampled this cycle; the FIFO decides on the same edge the FSM leaves STOP.
    logic push_req, pop, full, push_ok;
    assign push_req = (state == STOP) && (cyc == CYC_LAST) && rx_s && !par_bad;
    assign full     = (count == CNT_FULL);
    assign pop      = rd_en && valid;
    assign push_ok  = push_req && (!full || pop);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;

    // NOTE: storage is not reset; count gates what is visible, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rxdone  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            rxdone  <= push_ok;
            overrun <= push_req && !push_ok;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != '0);
    assign rxout = valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit, 8 data bits, 4-entry FIFO.
module tb_uart_rx_fifo;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Stop bit is sampled 10.5 clocks into its bit period; rd_en here lands on the push edge.
    localparam int POP_AT = CPB * (NB - 1) + 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rxout;
    logic       valid;
    logic [2:0] count;
    logic       rxdone, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad = 0;
    int n_done = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en),
        .rxout(rxout), .valid(valid), .count(count),
        .rxdone(rxdone), .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rxdone === 1'b1)    n_done++;
        if (frame_err === 1'b1) n_ferr++;
        if (overrun === 1'b1)   n_ovr++;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) n_perr++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; pop_at >= 0 raises rd_en for one clock at that offset.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_flip, input int pop_at);
        logic b;
        for (int i = 0; i < NB; i++) begin
            if (i == 0)            b = 1'b0;
            else if (i <= 8)       b = d[i-1];
            else if (i == NB - 1)  b = stop_bit;
            else                   b = (^d) ^ par_flip;
            rx = b;
            for (int c = 0; c < CPB; c++) begin
                rd_en = (i * CPB + c == pop_at);
                @(negedge clk);
            end
        end
        rd_en = 1'b0;
        if (stop_bit) rx = 1'b1;
        idle(4);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, rxout, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    int d0, f0, o0, p0;

    initial begin
        idle(3);
        check("rst_rxout", rxout, 0);
        check("rst_valid", valid, 0);
        check("rst_count", count, 0);
        check("rst_pulses", {rxdone, frame_err, overrun}, 0);
        rst_n = 1'b1;
        idle(3);

        // Single frame and pop
        d0 = n_done;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        check("a5_rxdone", n_done - d0, 1);
        check("a5_valid", valid, 1);
        check("a5_count", count, 1);
        pop_check("a5_rxout", 8'hA5);
        check("a5_empty_valid", valid, 0);
        check("a5_empty_rxout", rxout, 0);

        // Short low glitch is rejected in START
        d0 = n_done; f0 = n_ferr; o0 = n_ovr;
        rx = 1'b0; idle(4); rx = 1'b1; idle(40);
        check("glitch_pulses", (n_done - d0) + (n_ferr - f0) + (n_ovr - o0), 0);
        check("glitch_count", count, 0);

        // Bad stop bit followed by a 100-cycle break
        d0 = n_done; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        idle(100);
        rx = 1'b1;
        idle(20);
        check("brk_frame_err", n_ferr - f0, 1);
        check("brk_rxdone", n_done - d0, 0);
        check("brk_count", count, 0);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        check("brk_next_count", count, 1);
        pop_check("brk_next_rxout", 8'h11);

        // Fill past capacity
        d0 = n_done; o0 = n_ovr;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
        check("ovr_rxdone", n_done - d0, 4);
        check("ovr_overrun", n_ovr - o0, 1);
        check("ovr_count", count, 4);
        check("ovr_head", rxout, 8'h01);
        for (int i = 1; i <= 4; i++) pop_check("ovr_pop", 8'(i));
        check("ovr_drained", valid, 0);
        rd_en = 1'b1; idle(1); rd_en = 1'b0;
        check("pop_empty_count", count, 0);

        // Push and pop on the same edge while full
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
        d0 = n_done; o0 = n_ovr;
        send_frame(8'h55, 1'b1, 1'b0, POP_AT);
        check("pp_overrun", n_ovr - o0, 0);
        check("pp_rxdone", n_done - d0, 1);
        check("pp_count", count, 4);
        pop_check("pp_pop0", 8'h02);
        pop_check("pp_pop1", 8'h03);
        pop_check("pp_pop2", 8'h04);
        pop_check("pp_pop3", 8'h55);
        check("pp_drained", count, 0);

        // Reset mid-DATA with two bytes buffered
        send_frame(8'h21, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        check("mr_pre_count", count, 2);
        d0 = n_done; f0 = n_ferr;
        fork
            send_frame(8'hFF, 1'b1, 1'b0, -1);
            begin
                idle(60);
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
                check("mr_count", count, 0);
                check("mr_valid", valid, 0);
            end
        join
        check("mr_aborted", (n_done - d0) + (n_ferr - f0), 0);
        send_frame(8'h0F, 1'b1, 1'b0, -1);
        check("mr_next_count", count, 1);
        pop_check("mr_next_rxout", 8'h0F);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight; parity bit 0 is wrong under even parity
        d0 = n_done; p0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b1, -1);
        check("par_err", n_perr - p0, 1);
        check("par_rxdone", n_done - d0, 0);
        check("par_count", count, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
